// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: 16x8 register bank shared by an SPI slave and a core port, with SPI priority
// Ports: clk, reset (async, active-low); spi_cs/spi_rx_valid/spi_rx_data in from the SPI shifter,
// spi_tx_data/spi_tx_load out to it; core_req/core_we/core_addr/core_wdata in,
// core_gnt/core_rdata/core_rvalid out; busy = SPI transaction in progress.
module spi_reg_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_rx_valid,
  input  logic [7:0] spi_rx_data,
  output logic [7:0] spi_tx_data,
  output logic       spi_tx_load,
  input  logic       core_req,
  input  logic       core_we,
  input  logic [6:0] core_addr,
  input  logic [7:0] core_wdata,
  output logic       core_gnt,
  output logic [7:0] core_rdata,
  output logic       core_rvalid,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CMD, DATA_WR, DATA_RD} state_t;
  state_t state_q, state_d;
  logic cs_s1_q, cs_s2_q;
  logic [1:0] fill_q;
  logic armed_q, armed_d;
  logic [6:0] ptr_q, ptr_d;
  logic rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] regs_q [16];
  logic [7:0] tx_data_q, rdata_q;
  logic tx_load_q, rvalid_q;
  logic cs_low, rx, spi_rd, spi_wr, we;
  logic [6:0] raddr, waddr;
  logic [7:0] rval, wval;
  assign cs_low = ~cs_s2_q;
  assign rx = spi_rx_valid & cs_low & (state_q != IDLE);
  // Pending SPI accesses die in the same cycle chip select is seen high
  assign spi_rd = rd_pend_q & cs_low;
  assign spi_wr = wr_pend_q & cs_low;
  assign core_gnt = reset & core_req & ~(spi_rd | spi_wr);
  assign raddr = spi_rd ? ptr_q : core_addr;
  assign rval = (raddr < 7'd16) ? regs_q[raddr[3:0]] : 8'h00;
  assign we = spi_wr | (core_gnt & core_we);
  assign waddr = spi_wr ? ptr_q : core_addr;
  assign wval = spi_wr ? wdata_q : core_wdata;
  assign spi_tx_data = tx_data_q;
  assign spi_tx_load = tx_load_q & cs_low;
  assign core_rdata = rdata_q;
  assign core_rvalid = rvalid_q;
  assign busy = (state_q != IDLE);
  always_comb begin
    state_d = state_q;
    ptr_d = spi_wr ? ptr_q + 7'd1 : ptr_q;
    rd_pend_d = 1'b0;
    wr_pend_d = 1'b0;
    wdata_d = wdata_q;
    // Arm only once a genuine deselect has travelled through the sync chain after reset
    armed_d = armed_q | (fill_q[1] & cs_s2_q);
    if (state_q != IDLE && !cs_low) state_d = IDLE;
    else case (state_q)
      IDLE: state_d = (armed_q & cs_low) ? CMD : IDLE;
      CMD: if (rx) begin
        state_d = spi_rx_data[7] ? DATA_WR : DATA_RD;
        ptr_d = spi_rx_data[6:0];
        rd_pend_d = ~spi_rx_data[7];
      end
      DATA_WR: if (rx) begin
        wr_pend_d = 1'b1;
        wdata_d = spi_rx_data;
      end
      default: if (rx) begin
        ptr_d = ptr_q + 7'd1;
        rd_pend_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cs_s1_q <= 1'b1;
      cs_s2_q <= 1'b1;
      fill_q <= 2'b00;
      armed_q <= 1'b0;
      ptr_q <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wdata_q <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_s1_q <= spi_cs;
      cs_s2_q <= cs_s1_q;
      fill_q <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      ptr_q <= ptr_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      wdata_q <= wdata_d;
      tx_data_q <= spi_rd ? rval : tx_data_q;
      tx_load_q <= spi_rd;
      rdata_q <= (core_gnt & ~core_we) ? rval : rdata_q;
      rvalid_q <= core_gnt & ~core_we;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    else if (we && waddr < 7'd16) regs_q[waddr[3:0]] <= wval;
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed scoreboard bench for spi_reg_arbiter
module tb_spi_reg_arbiter;
  logic clk = 0, reset = 0, spi_cs = 1, spi_rx_valid = 0;
  logic [7:0] spi_rx_data = 0, core_wdata = 0;
  logic core_req = 1, core_we = 0;
  logic [6:0] core_addr = 0;
  logic [7:0] spi_tx_data, core_rdata;
  logic spi_tx_load, core_gnt, core_rvalid, busy;
  int tests = 0, fails = 0, cyc = 0, loads = 0, l0;
  typedef struct {logic [7:0] d; int c;} tx_t;
  tx_t txq[$];
  logic [7:0] cq[$];

  spi_reg_arbiter dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_rx_valid(spi_rx_valid),
    .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data), .spi_tx_load(spi_tx_load),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expected bytes as the DUT produces them
  always @(negedge clk) begin
    if (spi_tx_load) begin
      loads++;
      chk("tx_expected", txq.size() > 0, 1);
      if (txq.size() > 0) begin
        tx_t e;
        e = txq.pop_front();
        chk("tx_data", spi_tx_data, e.d);
        chk("tx_latency", cyc, e.c);
      end
    end
    if (core_rvalid) begin
      chk("rvalid_expected", cq.size() > 0, 1);
      if (cq.size() > 0) chk("core_rdata", core_rdata, cq.pop_front());
    end
  end

  task automatic spi_byte(input logic [7:0] b, input bit rd, input logic [7:0] exp);
    @(negedge clk);
    spi_rx_valid = 1;
    spi_rx_data = b;
    if (rd) txq.push_back('{exp, cyc + 2});
    @(negedge clk);
    spi_rx_valid = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_go(input logic v);
    @(negedge clk);
    spi_cs = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic core_acc(input string tag, input logic we, input logic [6:0] a,
                          input logic [7:0] wd, input logic [7:0] exp);
    bit g;
    g = 0;
    @(negedge clk);
    core_req = 1;
    core_we = we;
    core_addr = a;
    core_wdata = wd;
    for (int i = 0; i < 16 && !g; i++) begin
      #1 g = core_gnt;
      if (!g) @(negedge clk);
    end
    chk({tag, "_gnt"}, g, 1);
    if (g && !we) cq.push_back(exp);
    @(negedge clk);
    core_req = 0;
    chk({tag, "_rvalid"}, core_rvalid, !we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a core request pending
    repeat (2) @(negedge clk);
    chk("rst_gnt", core_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txload", spi_tx_load, 0);
    chk("rst_txdata", spi_tx_data, 0);
    chk("rst_rvalid", core_rvalid, 0);
    chk("rst_rdata", core_rdata, 0);
    core_req = 0;
    reset = 1;
    repeat (4) @(negedge clk);

    // SPI write burst: 0x83, 0xAA, 0x55
    cs_go(0);
    chk("cmd_busy", busy, 1);
    spi_byte(8'h83, 0, 0);
    spi_byte(8'hAA, 0, 0);
    spi_byte(8'h55, 0, 0);
    chk("wr_ptr", dut.ptr_q, 7'h05);
    cs_go(1);
    chk("idle_busy", busy, 0);

    // SPI read burst: 0x03 then two dummies -> 0xAA, 0x55, 0x00
    cs_go(0);
    spi_byte(8'h03, 1, 8'hAA);
    spi_byte(8'h00, 1, 8'h55);
    spi_byte(8'h00, 1, 8'h00);
    cs_go(1);

    // Core request held over an SPI write cycle
    cs_go(0);
    spi_byte(8'h8A, 0, 0);
    @(negedge clk); spi_rx_valid = 1; spi_rx_data = 8'h77;
    @(negedge clk); spi_rx_valid = 0; core_req = 1; core_we = 0; core_addr = 7'd3;
    #1 chk("gnt_blocked", core_gnt, 0);
    @(negedge clk); #1 chk("gnt_next", core_gnt, 1);
    cq.push_back(8'hAA);
    @(negedge clk); core_req = 0;
    chk("rvalid_after_gnt", core_rvalid, 1);
    repeat (4) @(negedge clk);
    // Same-address collision: SPI write lands, core write retries and lands after
    @(negedge clk); spi_rx_valid = 1; spi_rx_data = 8'h66;
    @(negedge clk); spi_rx_valid = 0; core_req = 1; core_we = 1; core_addr = 7'd11; core_wdata = 8'h99;
    #1 chk("coll_blocked", core_gnt, 0);
    @(negedge clk); #1 chk("coll_retry", core_gnt, 1);
    @(negedge clk); core_req = 0;
    chk("coll_no_rvalid", core_rvalid, 0);
    repeat (4) @(negedge clk);
    cs_go(1);
    core_acc("rd10", 0, 7'd10, 0, 8'h77);
    core_acc("rd11", 0, 7'd11, 0, 8'h99);
    core_acc("rd4", 0, 7'd4, 0, 8'h55);

    // Pointer wrap: 0xFF, 0x11, 0x22
    cs_go(0);
    spi_byte(8'hFF, 0, 0);
    spi_byte(8'h11, 0, 0);
    spi_byte(8'h22, 0, 0);
    cs_go(1);
    core_acc("rd0_wrap", 0, 7'd0, 0, 8'h22);
    core_acc("rd15", 0, 7'd15, 0, 8'h00);
    core_acc("rd7f", 0, 7'h7F, 0, 8'h00);
    core_acc("wr20", 1, 7'h20, 8'h5A, 0);
    core_acc("rd20", 0, 7'h20, 0, 8'h00);
    core_acc("rd4_alias", 0, 7'd4, 0, 8'h55);

    // Deselect right after a read command: synchronized cs high the cycle after it
    cs_go(0);
    @(negedge clk); spi_cs = 1;
    @(negedge clk); spi_rx_valid = 1; spi_rx_data = 8'h03; l0 = loads;
    @(negedge clk); spi_rx_valid = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_load", loads, l0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a write transaction
    cs_go(0);
    spi_byte(8'h81, 0, 0);
    spi_byte(8'h34, 0, 0);
    core_acc("pre_rd0", 0, 7'd0, 0, 8'h22);
    @(negedge clk); core_req = 1; core_we = 0; core_addr = 7'd1;
    #2 reset = 0;
    #1;
    chk("mid_rst_gnt", core_gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_txload", spi_tx_load, 0);
    chk("mid_rst_txdata", spi_tx_data, 0);
    chk("mid_rst_rvalid", core_rvalid, 0);
    chk("mid_rst_rdata", core_rdata, 0);
    chk("mid_rst_ptr", dut.ptr_q, 0);
    @(negedge clk); core_req = 0;
    @(negedge clk); reset = 1;
    repeat (4) @(negedge clk);
    l0 = loads;
    spi_byte(8'h12, 0, 0);
    chk("post_rst_ignored", busy, 0);
    chk("post_rst_no_load", loads, l0);
    core_acc("post_rst_rd1", 0, 7'd1, 0, 8'h00);
    cs_go(1);
    cs_go(0);
    chk("rearmed_busy", busy, 1);
    spi_byte(8'h81, 0, 0);
    spi_byte(8'h12, 0, 0);
    cs_go(1);
    core_acc("rd1_new", 0, 7'd1, 0, 8'h12);
    core_acc("rd3_cleared", 0, 7'd3, 0, 8'h00);
    core_acc("rd0_cleared", 0, 7'd0, 0, 8'h00);

    repeat (4) @(negedge clk);
    chk("txq_drained", txq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
